activation_writeback: RTL and testbench

- Sits directly downstream of the two-column leaky ReLU stage.
- Column 2 of each row arrives one or more cycles after column 1. This block re-pairs the staggered column outputs into aligned rows, packs each row into one 32-bit word and writes it sequentially into the unified buffer from a programmable base address.
- A start/busy/done FSM controls each transfer. A sticky error flag reports skew violations.

---
 rtl/activation_writeback.sv | 138 +++++++++++++
 tb/tb_activation_writeback.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/activation_writeback.sv
// activation_writeback
//   Re-pairs the staggered column-1 / column-2 outputs of the two-column
//   leaky ReLU stage into aligned rows and writes each row as one 32-bit
//   word {col2, col1} to consecutive unified-buffer addresses starting at a
//   programmable base. A start/busy/done FSM frames each transfer and a
//   sticky error flag reports skew violations.
//
// Ports
//   clk, rst                          clock, async active-high reset
//   wb_start_in                       start pulse (accepted only in IDLE)
//   wb_base_addr_in, wb_num_rows_in   transfer setup, sampled on start
//   wb_valid_1_in, wb_data_1_in       column-1 element (Q8.8)
//   wb_valid_2_in, wb_data_2_in       column-2 element (Q8.8)
//   wb_mem_wr_en_out/addr_out/data_out  registered buffer write port
//   wb_busy_out, wb_done_out, wb_err_out  status
module activation_writeback #(
   parameter int ADDR_W     = 8,
   parameter int SKEW_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_start_in,
   input  logic [ADDR_W-1:0] wb_base_addr_in,
   input  logic [ADDR_W-1:0] wb_num_rows_in,
   input  logic              wb_valid_1_in,
   input  logic              wb_valid_2_in,
   input  logic [15:0]       wb_data_1_in,
   input  logic [15:0]       wb_data_2_in,
   output logic              wb_mem_wr_en_out,
   output logic [ADDR_W-1:0] wb_mem_addr_out,
   output logic [31:0]       wb_mem_data_out,
   output logic              wb_busy_out,
   output logic              wb_done_out,
   output logic              wb_err_out
);

   localparam int PTR_W = $clog2(SKEW_DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] num_rows;
   logic [ADDR_W-1:0] row_count;

   logic [15:0]       fifo [SKEW_DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W:0]    fill;

   logic        active;
   logic        fifo_empty;
   logic        fifo_full;
   logic        bypass;
   logic        pop;
   logic        push;
   logic        pair;
   logic        skew_err;
   logic [15:0] pair_lo;

   // Pairing is only live while rows remain; once the last pair is formed
   // the write cycle still sits in RUN but further valids are ignored.
   always_comb begin
      active     = (state == RUN) && (row_count != num_rows);
      fifo_empty = (fill == '0);
      fifo_full  = (fill == (PTR_W+1)'(SKEW_DEPTH));
      bypass     = active && wb_valid_1_in && wb_valid_2_in && fifo_empty;
      pop        = active && wb_valid_2_in && !fifo_empty;
      // A pop in the same cycle frees the head slot, so a full FIFO can
      // still accept the new column-1 value.
      push       = active && wb_valid_1_in && !bypass && (!fifo_full || pop);
      pair       = bypass || pop;
      pair_lo    = bypass ? wb_data_1_in : fifo[rd_ptr];
      skew_err   = active && ((wb_valid_2_in && fifo_empty && !wb_valid_1_in) ||
                              (wb_valid_1_in && fifo_full && !pop));
   end

   // Holding storage carries no reset; occupancy is tracked by fill.
   always_ff @(posedge clk) begin
      if (push) fifo[wr_ptr] <= wb_data_1_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         base             <= '0;
         num_rows         <= '0;
         row_count        <= '0;
         rd_ptr           <= '0;
         wr_ptr           <= '0;
         fill             <= '0;
         wb_mem_wr_en_out <= 1'b0;
         wb_mem_addr_out  <= '0;
         wb_mem_data_out  <= '0;
         wb_err_out       <= 1'b0;
      end else begin
         wb_mem_wr_en_out <= 1'b0;
         case (state)
            IDLE: begin
               if (wb_start_in) begin
                  base       <= wb_base_addr_in;
                  num_rows   <= wb_num_rows_in;
                  row_count  <= '0;
                  rd_ptr     <= '0;
                  wr_ptr     <= '0;
                  fill       <= '0;
                  wb_err_out <= 1'b0;
                  state      <= (wb_num_rows_in == '0) ? DONE : RUN;
               end
            end
            RUN: begin
               if (active) begin
                  if (pair) begin
                     wb_mem_wr_en_out <= 1'b1;
                     wb_mem_addr_out  <= base + row_count;
                     wb_mem_data_out  <= {wb_data_2_in, pair_lo};
                     row_count        <= row_count + ADDR_W'(1);
                  end
                  if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                  if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                  if (push && !pop)      fill <= fill + (PTR_W+1)'(1);
                  else if (pop && !push) fill <= fill - (PTR_W+1)'(1);
                  if (skew_err) wb_err_out <= 1'b1;
               end else begin
                  // Final write is on the port this cycle.
                  state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign wb_busy_out = (state == RUN);
   assign wb_done_out = (state == DONE);

endmodule

// File: tb/tb_activation_writeback.sv
module tb_activation_writeback;
   localparam int ADDR_W = 8;
   localparam int DEPTH  = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  base_in, rows_in;
   logic        v1, v2;
   logic [15:0] d1, d2;
   logic        wr_en, busy, done, err;
   logic [7:0]  addr;
   logic [31:0] data;

   always #5 clk = ~clk;

   activation_writeback #(.ADDR_W(ADDR_W), .SKEW_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .wb_start_in(start), .wb_base_addr_in(base_in), .wb_num_rows_in(rows_in),
      .wb_valid_1_in(v1), .wb_valid_2_in(v2),
      .wb_data_1_in(d1), .wb_data_2_in(d2),
      .wb_mem_wr_en_out(wr_en), .wb_mem_addr_out(addr), .wb_mem_data_out(data),
      .wb_busy_out(busy), .wb_done_out(done), .wb_err_out(err)
   );

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   wr_t         exp_q[$];
   logic [15:0] mq[$];          // model of column-1 values awaiting column 2
   int  tests = 0, fails = 0;
   int  cyc = 0;
   bit  m_busy = 0;
   int  m_base, m_rows, m_cnt;
   bit  exp_err = 0;
   int  exp_done_cyc = -1;
   int  done_seen = 0;
   logic [15:0] c1 [16];
   logic [15:0] c2 [16];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT writes, checks done framing.
   always @(negedge clk) begin
      if (!rst) begin
         if (wr_en) begin
            if (exp_q.size() == 0) check("unexpected_write", {24'h0, addr}, 32'hFFFF_FFFF);
            else begin
               wr_t e;
               e = exp_q.pop_front();
               check("wr_addr", {24'h0, addr}, {24'h0, e.addr});
               check("wr_data", data, e.data);
               check("wr_cycle", cyc, e.cyc);
            end
         end
         if (done) begin
            check("done_cycle", cyc, exp_done_cyc);
            check("err_at_done", {31'h0, err}, {31'h0, exp_err});
            check("busy_at_done", {31'h0, busy}, 32'h0);
            check("pending_writes", exp_q.size(), 0);
            exp_done_cyc = -1;
            done_seen++;
         end
      end
   end

   // Reference model: one call per driven cycle, at the behavioural level.
   task automatic model_step(input bit s, input logic [7:0] b, input logic [7:0] r,
                             input bit a1, input logic [15:0] x1,
                             input bit a2, input logic [15:0] x2);
      bit paired, byp;
      logic [15:0] lo;
      wr_t w;
      paired = 0; byp = 0; lo = '0;
      if (s && !m_busy && exp_done_cyc < 0) begin
         m_base = b; m_rows = r; m_cnt = 0; mq.delete(); exp_err = 0;
         if (r == 0) exp_done_cyc = cyc + 1;
         else        m_busy = 1;
      end else if (m_busy) begin
         if (a2) begin
            if (mq.size() > 0) begin lo = mq.pop_front(); paired = 1; end
            else if (a1)       begin lo = x1; paired = 1; byp = 1; end
            else exp_err = 1;
         end
         if (a1 && !byp) begin
            if (mq.size() < DEPTH) mq.push_back(x1);
            else exp_err = 1;
         end
         if (paired) begin
            w.addr = 8'((m_base + m_cnt) % 256);
            w.data = {x2, lo};
            w.cyc  = cyc + 1;
            exp_q.push_back(w);
            m_cnt++;
            if (m_cnt == m_rows) begin
               m_busy = 0;
               exp_done_cyc = cyc + 2;
            end
         end
      end
   endtask

   task automatic drive(input bit s, input logic [7:0] b, input logic [7:0] r,
                        input bit a1, input logic [15:0] x1,
                        input bit a2, input logic [15:0] x2);
      @(posedge clk); #1;
      start = s; base_in = b; rows_in = r; v1 = a1; d1 = x1; v2 = a2; d2 = x2;
      model_step(s, b, r, a1, x1, a2, x2);
   endtask

   task automatic idle();
      drive(0, 8'h0, 8'h0, 0, 16'h0, 0, 16'h0);
   endtask

   task automatic wait_done(input int d0);
      for (int i = 0; i < 20 && done_seen == d0; i++) idle();
      if (done_seen == d0) check("done_timeout", 0, 1);
      idle();
   endtask

   // Column 1 sends c1[0..n-1] from t=0, column 2 sends c2[] lagging by k.
   // If the model is still busy afterwards (dropped data), paired beats are
   // forced until the transfer completes.
   task automatic run_stream(input logic [7:0] b, input logic [7:0] r, input int k,
                             input int n, input int restart_at);
      int d0;
      d0 = done_seen;
      drive(1, b, r, 0, 16'h0, 0, 16'h0);
      for (int t = 0; t < n + k && m_busy; t++) begin
         bit a1, a2;
         a1 = (t < n);
         a2 = (t >= k) && (t - k < n);
         drive(t == restart_at, b ^ 8'h80, r, a1, a1 ? c1[t % 16] : 16'h0,
               a2, a2 ? c2[(t - k) % 16] : 16'h0);
      end
      for (int i = 0; i < 300 && m_busy; i++)
         drive(0, 0, 0, 1, 16'($urandom), 1, 16'($urandom));
      wait_done(d0);
   endtask

   task automatic fill_random();
      for (int i = 0; i < 16; i++) begin
         c1[i] = 16'($urandom);
         c2[i] = 16'($urandom);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int d0;
      rst = 1; start = 0; base_in = 0; rows_in = 0; v1 = 0; v2 = 0; d1 = 0; d2 = 0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", {26'h0, wr_en, busy, done, err, 2'b00} | {addr, 24'h0} | data, 32'h0);
      rst = 0;
      idle();

      // Skew 1 with the documented values.
      c1[0] = 16'h0100; c1[1] = 16'hFF80; c1[2] = 16'h0200;
      c2[0] = 16'h0080; c2[1] = 16'h0300; c2[2] = 16'hFE00;
      run_stream(8'h10, 8'd3, 1, 3, -1);

      // Zero skew (bypass) and full-depth skew.
      fill_random(); run_stream(8'h20, 8'd2, 0, 2, -1);
      fill_random(); run_stream(8'h30, 8'd6, 4, 6, -1);
      // Skew 5: fifth column-1 value is dropped, error raised.
      fill_random(); run_stream(8'h40, 8'd6, 5, 8, -1);

      // Column 2 ahead of column 1: error and no write, then a clean stream.
      d0 = done_seen;
      drive(1, 8'h50, 8'd1, 0, 16'h0, 0, 16'h0);
      drive(0, 0, 0, 0, 16'h0, 1, 16'h1234);
      drive(0, 0, 0, 1, 16'hAAAA, 0, 16'h0);
      drive(0, 0, 0, 0, 16'h0, 1, 16'h5555);
      wait_done(d0);
      fill_random(); run_stream(8'h60, 8'd3, 2, 3, -1);

      // Address wrap, zero rows, start while busy.
      fill_random(); run_stream(8'hFE, 8'd3, 2, 3, -1);
      d0 = done_seen;
      drive(1, 8'h70, 8'd0, 1, 16'h1111, 1, 16'h2222);
      wait_done(d0);
      fill_random(); run_stream(8'h80, 8'd4, 1, 4, 2);

      // Reset after the first of four writes.
      d0 = done_seen;
      drive(1, 8'h90, 8'd4, 0, 16'h0, 0, 16'h0);
      drive(0, 0, 0, 1, 16'h0A0B, 1, 16'h0C0D);
      idle();
      @(posedge clk); #2;
      rst = 1;
      #1;
      check("abort_wr_en", {31'h0, wr_en}, 32'h0);
      check("abort_status", {29'h0, busy, done, err}, 32'h0);
      check("abort_addr_data", data | {24'h0, addr}, 32'h0);
      exp_q.delete(); mq.delete(); m_busy = 0; exp_done_cyc = -1;
      @(posedge clk); #1;
      rst = 0;
      repeat (3) idle();
      check("no_done_after_reset", done_seen, d0);
      fill_random(); run_stream(8'h90, 8'd4, 2, 4, -1);

      // Randomized transfers with random valids and start attempts mid-run.
      for (int it = 0; it < 8; it++) begin
         logic [7:0] b, r;
         int lim;
         b = 8'($urandom); r = 8'($urandom_range(1, 10));
         lim = 4 * int'(r);
         d0 = done_seen;
         drive(1, b, r, 0, 16'h0, 0, 16'h0);
         for (int t = 0; t < lim && m_busy; t++)
            drive(($urandom % 8) == 0, 8'($urandom), 8'($urandom),
                  ($urandom % 3) != 0, 16'($urandom), ($urandom % 2) == 0, 16'($urandom));
         for (int i = 0; i < 300 && m_busy; i++)
            drive(0, 0, 0, 1, 16'($urandom), 1, 16'($urandom));
         wait_done(d0);
      end

      repeat (2) idle();
      check("final_queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
